// File: rtl/signal_monitor.sv
// rtl/signal_monitor.sv - traffic-light lamp monitor with phase decode, fault latch, dwell counter and walk permit
//
// Purpose:
//   Watches the lamp codes driven by a two-light traffic controller. It decodes
//   the combined phase, counts cycles spent in that phase, and latches the first
//   detected safety fault. Pedestrian walk is granted after a long enough
//   all-red interval while no fault is latched.
//
// Ports:
//   clk          in   1   single clock, everything on posedge
//   reset        in   1   synchronous, active-high
//   Light1       in   3   lamp code light 1 (100 red, 010 yellow, 001 green, 000 off)
//   Light2       in   3   lamp code light 2, same encoding
//   fault_clear  in   1   clears the latched fault
//   phase        out  3   decoded phase of the registered lamp codes
//   walk         out  1   pedestrian walk permitted
//   fault        out  1   sticky fault flag
//   fault_code   out  3   cause of the first latched fault
//   dwell        out  32  cycles in current phase, saturating
//
// Configuration:
//   SIGNAL_MONITOR_YELLOW_CHECK_EN - when defined, a light leaving yellow for
//   red before YELLOW_MIN cycles of dwell raises fault code 100.

module signal_monitor #(
  parameter int unsigned YELLOW_MIN = 50000000,
  parameter int unsigned WALK_DELAY = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  Light1,
  input  logic [2:0]  Light2,
  input  logic        fault_clear,
  output logic [2:0]  phase,
  output logic        walk,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [31:0] dwell
);

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b100;

  localparam logic [2:0] PH_ALL_RED   = 3'b000;
  localparam logic [2:0] PH_L1_GREEN  = 3'b001;
  localparam logic [2:0] PH_L1_YELLOW = 3'b010;
  localparam logic [2:0] PH_L2_GREEN  = 3'b011;
  localparam logic [2:0] PH_L2_YELLOW = 3'b100;
  localparam logic [2:0] PH_DARK      = 3'b101;
  localparam logic [2:0] PH_INVALID   = 3'b110;

  localparam logic [2:0] FC_NONE     = 3'b000;
  localparam logic [2:0] FC_CONFLICT = 3'b001;
  localparam logic [2:0] FC_INVALID  = 3'b010;
  localparam logic [2:0] FC_SEQUENCE = 3'b011;
  localparam logic [2:0] FC_SHORT_YE = 3'b100;

  logic [2:0]  l1_q, l1_d;
  logic [2:0]  l2_q, l2_d;
  logic [2:0]  l1_prev_q, l1_prev_d;
  logic [2:0]  l2_prev_q, l2_prev_d;
  logic [2:0]  phase_q, phase_d;
  logic [31:0] dwell_q, dwell_d;
  logic        fault_q, fault_d;
  logic [2:0]  fault_code_q, fault_code_d;

  logic        conflict;
  logic        invalid_code;
  logic        seq_error;
  logic        yellow_short;
  logic [2:0]  cause;

  function automatic logic is_legal(input logic [2:0] c);
    return (c == LAMP_OFF) || (c == LAMP_GRN) || (c == LAMP_YEL) || (c == LAMP_RED);
  endfunction

  // "Active" means the lamp is showing something that lets traffic move.
  function automatic logic is_active(input logic [2:0] c);
    return (c != LAMP_RED) && (c != LAMP_OFF);
  endfunction

  function automatic logic step_ok(input logic [2:0] prev, input logic [2:0] cur);
    return (prev == cur) || (cur == LAMP_OFF) || (prev == LAMP_OFF) ||
           ((prev == LAMP_RED) && (cur == LAMP_GRN)) ||
           ((prev == LAMP_GRN) && (cur == LAMP_YEL)) ||
           ((prev == LAMP_YEL) && (cur == LAMP_RED));
  endfunction

  function automatic logic [2:0] decode(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] p;
    p = PH_INVALID;
    if      ((a == LAMP_RED) && (b == LAMP_RED)) p = PH_ALL_RED;
    else if ((a == LAMP_GRN) && (b == LAMP_RED)) p = PH_L1_GREEN;
    else if ((a == LAMP_YEL) && (b == LAMP_RED)) p = PH_L1_YELLOW;
    else if ((a == LAMP_RED) && (b == LAMP_GRN)) p = PH_L2_GREEN;
    else if ((a == LAMP_RED) && (b == LAMP_YEL)) p = PH_L2_YELLOW;
    else if ((a == LAMP_OFF) && (b == LAMP_OFF)) p = PH_DARK;
    return p;
  endfunction

`ifdef SIGNAL_MONITOR_YELLOW_CHECK_EN
  // dwell_q still belongs to the yellow phase in the cycle the red code is
  // first seen, so it is the length of the yellow interval just ending.
  assign yellow_short = (((l1_prev_q == LAMP_YEL) && (l1_q == LAMP_RED)) ||
                         ((l2_prev_q == LAMP_YEL) && (l2_q == LAMP_RED))) &&
                        (dwell_q < YELLOW_MIN);
`else
  // Check compiled out: the term is constant zero, so no code-100 path exists.
  assign yellow_short = 1'b0 & (dwell_q < YELLOW_MIN);
`endif

  always_comb begin
    conflict     = is_active(l1_q) && is_active(l2_q);
    invalid_code = !is_legal(l1_q) || !is_legal(l2_q);
    seq_error    = !step_ok(l1_prev_q, l1_q) || !step_ok(l2_prev_q, l2_q);

    cause = FC_NONE;
    if      (conflict)     cause = FC_CONFLICT;
    else if (invalid_code) cause = FC_INVALID;
    else if (seq_error)    cause = FC_SEQUENCE;
    else if (yellow_short) cause = FC_SHORT_YE;
  end

  always_comb begin
    l1_d      = Light1;
    l2_d      = Light2;
    l1_prev_d = l1_q;
    l2_prev_d = l2_q;

    phase_d = decode(l1_q, l2_q);

    if (phase_d != phase_q)          dwell_d = '0;
    else if (dwell_q == 32'hFFFFFFFF) dwell_d = dwell_q;
    else                              dwell_d = dwell_q + 32'd1;

    // A clear in the same cycle as a new cause re-arms with that cause.
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    if (fault_clear) begin
      fault_d      = (cause != FC_NONE);
      fault_code_d = cause;
    end else if (!fault_q && (cause != FC_NONE)) begin
      fault_d      = 1'b1;
      fault_code_d = cause;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l1_q         <= LAMP_OFF;
      l2_q         <= LAMP_OFF;
      l1_prev_q    <= LAMP_OFF;
      l2_prev_q    <= LAMP_OFF;
      phase_q      <= PH_DARK;
      dwell_q      <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      l1_q         <= l1_d;
      l2_q         <= l2_d;
      l1_prev_q    <= l1_prev_d;
      l2_prev_q    <= l2_prev_d;
      phase_q      <= phase_d;
      dwell_q      <= dwell_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Combinational so walk drops in the very cycle phase or fault changes.
  always_comb begin
    walk = (phase_q == PH_ALL_RED) && (dwell_q >= WALK_DELAY) && !fault_q;
  end

  assign phase      = phase_q;
  assign dwell      = dwell_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_signal_monitor.sv
// tb/tb_signal_monitor.sv - self-checking bench for signal_monitor with history-based reference model

module tb_signal_monitor;

  localparam int YM = 4;
  localparam int WD = 3;
  localparam int HMAX = 8192;

`ifdef SIGNAL_MONITOR_YELLOW_CHECK_EN
  localparam bit YCHK = 1'b1;
`else
  localparam bit YCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  Light1, Light2;
  logic        fault_clear;
  logic [2:0]  phase;
  logic        walk, fault;
  logic [2:0]  fault_code;
  logic [31:0] dwell;

  int nchk = 0;
  int nerr = 0;

  signal_monitor #(.YELLOW_MIN(YM), .WALK_DELAY(WD)) dut (
    .clk(clk), .reset(reset), .Light1(Light1), .Light2(Light2),
    .fault_clear(fault_clear), .phase(phase), .walk(walk), .fault(fault),
    .fault_code(fault_code), .dwell(dwell)
  );

  always #5 clk = ~clk;

  // Reference model: the full history of lamp codes sampled since the last
  // reset. Phase and dwell are derived from that history on demand.
  logic [2:0] h1 [HMAX];
  logic [2:0] h2 [HMAX];
  int         n = 0;
  bit         mvalid = 1'b0;
  bit         mf = 1'b0;
  int         mc = 0;

  function automatic logic [2:0] hs1(int i);
    return (i < 0) ? 3'd0 : h1[i];
  endfunction
  function automatic logic [2:0] hs2(int i);
    return (i < 0) ? 3'd0 : h2[i];
  endfunction

  function automatic int phase_of(logic [2:0] a, logic [2:0] b);
    case ({a, b})
      6'o44: return 0;
      6'o14: return 1;
      6'o24: return 2;
      6'o41: return 3;
      6'o42: return 4;
      6'o00: return 5;
      default: return 6;
    endcase
  endfunction

  // Phase visible after sample i (i = -1 is the reset edge).
  function automatic int mph(int i);
    return phase_of(hs1(i - 1), hs2(i - 1));
  endfunction

  // Cycles since the visible phase last changed.
  function automatic int mdw(int i);
    int j = i;
    while (j > -1 && mph(j - 1) == mph(i)) j--;
    return i - j;
  endfunction

  function automatic bit moving(logic [2:0] c);
    return !(c == 3'd0 || c == 3'd4);
  endfunction
  function automatic bit legal(logic [2:0] c);
    return c == 3'd0 || c == 3'd1 || c == 3'd2 || c == 3'd4;
  endfunction
  function automatic bit trans_ok(logic [2:0] p, logic [2:0] c);
    if (p == c || p == 3'd0 || c == 3'd0) return 1'b1;
    return ({p, c} == 6'o41) || ({p, c} == 6'o12) || ({p, c} == 6'o24);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      n = 0; mf = 1'b0; mc = 0; mvalid = 1'b1;
    end else begin
      logic [2:0] c1, c2, p1, p2;
      int cause, dw;
      c1 = hs1(n - 1); c2 = hs2(n - 1);
      p1 = hs1(n - 2); p2 = hs2(n - 2);
      dw = mdw(n - 1);
      cause = 0;
      if (moving(c1) && moving(c2))                     cause = 1;
      else if (!legal(c1) || !legal(c2))                cause = 2;
      else if (!trans_ok(p1, c1) || !trans_ok(p2, c2))  cause = 3;
      else if (YCHK && ((p1 == 3'd2 && c1 == 3'd4) || (p2 == 3'd2 && c2 == 3'd4)) && dw < YM)
        cause = 4;
      if (n < HMAX) begin
        h1[n] = Light1; h2[n] = Light2; n++;
      end
      if (fault_clear) begin
        mf = (cause != 0); mc = cause;
      end else if (!mf && cause != 0) begin
        mf = 1'b1; mc = cause;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      int ep, ed;
      ep = mph(n - 1);
      ed = mdw(n - 1);
      chk("phase", {29'd0, phase}, ep);
      chk("dwell", dwell, ed);
      chk("walk", {31'd0, walk}, {31'd0, (ep == 0 && ed >= WD && !mf)});
      chk("fault", {31'd0, fault}, {31'd0, mf});
      chk("fault_code", {29'd0, fault_code}, mc);
    end
  end

  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic clr, input logic rst);
    Light1 = a; Light2 = b; fault_clear = clr; reset = rst;
    @(negedge clk);
  endtask

  logic [2:0] plan1 [6] = '{3'd4, 3'd1, 3'd2, 3'd4, 3'd4, 3'd4};
  logic [2:0] plan2 [6] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd2};

  initial begin
    reset = 1'b1; Light1 = 3'd0; Light2 = 3'd0; fault_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_phase", {29'd0, phase}, 32'd5);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_code", {29'd0, fault_code}, 32'd0);
    chk("rst_dwell", dwell, 32'd0);
    chk("rst_walk", {31'd0, walk}, 32'd0);

    // L2 green held
    step(3'd4, 3'd1, 0, 0);
    step(3'd4, 3'd1, 0, 0);
    chk("l2g_phase", {29'd0, phase}, 32'd3);
    chk("l2g_fault", {31'd0, fault}, 32'd0);
    chk("l2g_dwell0", dwell, 32'd0);
    step(3'd4, 3'd1, 0, 0);
    chk("l2g_dwell1", dwell, 32'd1);
    step(3'd4, 3'd1, 0, 0);
    chk("l2g_dwell2", dwell, 32'd2);

    // conflict, then later causes ignored
    step(3'd1, 3'd1, 0, 0);
    step(3'd4, 3'd4, 0, 0);
    chk("conf_fault", {31'd0, fault}, 32'd1);
    chk("conf_code", {29'd0, fault_code}, 32'd1);
    step(3'd4, 3'd4, 0, 0);
    chk("conf_hold", {29'd0, fault_code}, 32'd1);
    step(3'd4, 3'd4, 1, 0);
    chk("conf_clear", {31'd0, fault}, 32'd0);

    // invalid code
    step(3'd6, 3'd4, 0, 0);
    step(3'd4, 3'd4, 0, 0);
    chk("inv_code", {29'd0, fault_code}, 32'd2);
    step(3'd4, 3'd4, 0, 0);
    step(3'd4, 3'd4, 1, 0);
    chk("inv_clear", {31'd0, fault}, 32'd0);

    // green straight to red, then via off
    step(3'd1, 3'd4, 0, 0);
    step(3'd4, 3'd4, 0, 0);
    step(3'd4, 3'd4, 0, 0);
    chk("seq_code", {29'd0, fault_code}, 32'd3);
    step(3'd4, 3'd4, 1, 0);
    step(3'd1, 3'd4, 0, 0);
    step(3'd0, 3'd4, 0, 0);
    step(3'd4, 3'd4, 0, 0);
    step(3'd4, 3'd4, 0, 0);
    chk("off_path_nofault", {31'd0, fault}, 32'd0);

    // short yellow, then walk after all-red dwell
    step(3'd1, 3'd4, 0, 0);
    step(3'd2, 3'd4, 0, 0);
    step(3'd2, 3'd4, 0, 0);
    step(3'd4, 3'd4, 0, 0);
    step(3'd4, 3'd4, 0, 0);
    chk("ye_fault", {31'd0, fault}, {31'd0, YCHK});
    chk("ye_code", {29'd0, fault_code}, YCHK ? 32'd4 : 32'd0);
    step(3'd4, 3'd4, 1, 0);
    step(3'd4, 3'd4, 0, 0);
    chk("walk_early", {31'd0, walk}, 32'd0);
    step(3'd4, 3'd4, 0, 0);
    chk("walk_on", {31'd0, walk}, 32'd1);
    chk("walk_phase", {29'd0, phase}, 32'd0);

    // reset in the middle of a fault
    step(3'd1, 3'd1, 0, 0);
    step(3'd4, 3'd4, 0, 0);
    chk("mid_fault", {31'd0, fault}, 32'd1);
    step(3'd4, 3'd4, 0, 1);
    chk("mid_rst_fault", {31'd0, fault}, 32'd0);
    chk("mid_rst_phase", {29'd0, phase}, 32'd5);
    step(3'd4, 3'd4, 0, 0);

    // randomized traffic plan with perturbations
    begin
      int left = 3000;
      int k = 0;
      while (left > 0) begin
        int hold = $urandom_range(1, 6);
        for (int h = 0; h < hold && left > 0; h++) begin
          logic [2:0] a, b;
          logic c, r;
          a = plan1[k]; b = plan2[k];
          if ($urandom_range(0, 99) < 8) a = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 99) < 5) b = 3'($urandom_range(0, 7));
          c = ($urandom_range(0, 99) < 4);
          r = ($urandom_range(0, 99) < 1);
          step(a, b, c, r);
          left--;
        end
        k = (k + 1) % 6;
      end
    end

    step(3'd4, 3'd4, 0, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
